spi_target: RTL and testbench

- SPI mode-0 target (slave) for the bench SD/peripheral model and the board-test loopback path. It is the far end of the card-side SPI bus driven by our SPI host controller.
- Oversamples sclk, mosi and _ss on the system clk, deserialises MSB-first bytes to a parallel strobe interface, and serialises bytes supplied by local logic onto miso.
- Optionally computes a CRC16 over the received bitstream so the host controller's CRC path can be checked end-to-end.

---
 rtl/spi_target.sv | 196 +++++++++++++++++++
 tb/tb_spi_target.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled sclk/mosi/_ss, MSB-first byte deserialiser and serialiser.
// Define SPI_TARGET_CRC_EN to compute CRC-16/CCITT over the received bitstream.
`timescale 1ns / 1ps

module spi_target #(
   parameter logic [7:0]  IDLE_BYTE   = 8'hFF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sclk_i,
   input  logic        mosi_i,
   input  logic        _ss_i,
   output logic        miso_o,
   output logic        miso_oe_o,
   output logic        frame_active_o,
   output logic [7:0]  rx_data_o,
   output logic        rx_valid_o,
   input  logic [7:0]  tx_data_i,
   input  logic        tx_load_i,
   output logic        tx_ready_o,
   output logic        tx_underrun_o,
   output logic        frame_abort_o,
   output logic [15:0] crc_out_o
);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
   logic                   sclk_prev_q, ss_prev_q;
   logic                   sclk_s, mosi_s, ss_s;
   logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
   logic                   start_frame, shift_in, load_byte;

   state_e      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [6:0]  rx_shift_q, rx_shift_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic [7:0]  tx_buf_q, tx_buf_d;
   logic        tx_ready_q, tx_ready_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        tx_underrun_q, tx_underrun_d;
   logic        frame_abort_q, frame_abort_d;

   // _ss chain resets low so a select already held low at reset release cannot start a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         ss_sync_q   <= '0;
         sclk_prev_q <= 1'b0;
         ss_prev_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], _ss_i};
         sclk_prev_q <= sclk_s;
         ss_prev_q   <= ss_s;
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign ss_rise   = ss_s & ~ss_prev_q;
   assign ss_fall   = ~ss_s & ss_prev_q;

   assign start_frame = (state_q == StIdle) && ss_fall;
   assign shift_in    = (state_q == StShift) && !ss_rise && sclk_rise;

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      rx_shift_d    = rx_shift_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      tx_buf_d      = tx_buf_q;
      tx_ready_d    = tx_ready_q;
      tx_shift_d    = tx_shift_q;
      tx_underrun_d = 1'b0;
      frame_abort_d = 1'b0;
      load_byte     = 1'b0;

      if (tx_load_i && tx_ready_q) begin
         tx_buf_d   = tx_data_i;
         tx_ready_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (start_frame) begin
               state_d   = StShift;
               bit_cnt_d = 3'd0;
               load_byte = 1'b1;
            end
         end
         StShift: begin
            if (ss_rise) begin
               state_d = StIdle;
               if (bit_cnt_q != 3'd0) begin
                  frame_abort_d = 1'b1;
                  bit_cnt_d     = 3'd0;
               end
            end else if (shift_in) begin
               rx_shift_d = {rx_shift_q[5:0], mosi_s};
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rx_data_d  = {rx_shift_q, mosi_s};
                  rx_valid_d = 1'b1;
               end
            end else if (sclk_fall) begin
               if (bit_cnt_q == 3'd0) begin
                  load_byte = 1'b1;
               end else begin
                  tx_shift_d = {tx_shift_q[6:0], 1'b0};
               end
            end
         end
      endcase

      // Consumption looks only at the registered buffer, so a same-cycle tx_load stays pending.
      if (load_byte) begin
         if (!tx_ready_q) begin
            tx_shift_d = tx_buf_q;
            tx_ready_d = 1'b1;
         end else begin
            tx_shift_d    = IDLE_BYTE;
            tx_underrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         bit_cnt_q     <= 3'd0;
         rx_shift_q    <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         tx_buf_q      <= '0;
         tx_ready_q    <= 1'b1;
         tx_shift_q    <= 8'hFF;
         tx_underrun_q <= 1'b0;
         frame_abort_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         rx_shift_q    <= rx_shift_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         tx_buf_q      <= tx_buf_d;
         tx_ready_q    <= tx_ready_d;
         tx_shift_q    <= tx_shift_d;
         tx_underrun_q <= tx_underrun_d;
         frame_abort_q <= frame_abort_d;
      end
   end

`ifdef SPI_TARGET_CRC_EN
   logic [15:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (start_frame) begin
         crc_d = 16'hFFFF;
      end else if (shift_in) begin
         crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ mosi_s) ? 16'h1021 : 16'h0000);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_q <= 16'hFFFF;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_out_o = crc_q;
`else
   assign crc_out_o = 16'hFFFF;
`endif

   assign miso_o         = tx_shift_q[7];
   assign miso_oe_o      = (state_q == StShift);
   assign frame_active_o = (state_q == StShift);
   assign rx_data_o      = rx_data_q;
   assign rx_valid_o     = rx_valid_q;
   assign tx_ready_o     = tx_ready_q;
   assign tx_underrun_o  = tx_underrun_q;
   assign frame_abort_o  = frame_abort_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a mode-0 host model drives frames and checks both directions.
`timescale 1ns / 1ps

module tb_spi_target;

   localparam int H = 8;  // sclk half period in clk cycles

   logic        clk, rst, sclk, mosi, ss_n;
   logic        miso, miso_oe, frame_active, rx_valid, tx_load, tx_ready, tx_underrun, frame_abort;
   logic [7:0]  rx_data, tx_data;
   logic [15:0] crc_out;

   int          n_cmp = 0;
   int          n_err = 0;
   int          rx_cnt = 0;
   int          uf_cnt = 0;
   int          ab_cnt = 0;
   logic [7:0]  last_rx = '0;

   spi_target dut (
      .clk           (clk),
      .rst           (rst),
      .sclk_i        (sclk),
      .mosi_i        (mosi),
      ._ss_i         (ss_n),
      .miso_o        (miso),
      .miso_oe_o     (miso_oe),
      .frame_active_o(frame_active),
      .rx_data_o     (rx_data),
      .rx_valid_o    (rx_valid),
      .tx_data_i     (tx_data),
      .tx_load_i     (tx_load),
      .tx_ready_o    (tx_ready),
      .tx_underrun_o (tx_underrun),
      .frame_abort_o (frame_abort),
      .crc_out_o     (crc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse monitors count cycles high, so a stretched strobe also shows up as a wrong count.
   always @(negedge clk) begin
      if (rx_valid) begin
         rx_cnt  <= rx_cnt + 1;
         last_rx <= rx_data;
      end
      if (tx_underrun) uf_cnt <= uf_cnt + 1;
      if (frame_abort) ab_cnt <= ab_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_miso"}, 32'(miso), 1);
      check_eq({tag, "_miso_oe"}, 32'(miso_oe), 0);
      check_eq({tag, "_frame_active"}, 32'(frame_active), 0);
      check_eq({tag, "_rx_data"}, 32'(rx_data), 0);
      check_eq({tag, "_rx_valid"}, 32'(rx_valid), 0);
      check_eq({tag, "_tx_ready"}, 32'(tx_ready), 1);
      check_eq({tag, "_tx_underrun"}, 32'(tx_underrun), 0);
      check_eq({tag, "_frame_abort"}, 32'(frame_abort), 0);
      check_eq({tag, "_crc"}, 32'(crc_out), 'hFFFF);
   endtask

   task automatic tx_push(input logic [7:0] b);
      @(posedge clk); #1;
      tx_data = b;
      tx_load = 1'b1;
      @(posedge clk); #1;
      tx_load = 1'b0;
   endtask

   task automatic frame_start();
      ss_n = 1'b0;
      repeat (H) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      repeat (H) @(posedge clk);
      #1;
   endtask

   // last: _ss rises together with the final sclk fall. late: tx_load lands on the
   // clk where the target performs the byte-boundary load after this byte.
   task automatic xfer(input logic [7:0] mo, input int nbits, input bit last, input bit late,
                       input logic [7:0] late_val, output logic [7:0] mi);
      mi = '0;
      for (int i = 0; i < nbits; i++) begin
         mosi = mo[7-i];
         repeat (H) @(posedge clk);
         #1;
         mi[7-i] = miso;
         sclk = 1'b1;
         repeat (H) @(posedge clk);
         #1;
         sclk = 1'b0;
         if (last && i == nbits - 1) ss_n = 1'b1;
      end
      if (late) begin
         repeat (2) @(posedge clk);
         #1;
         tx_data = late_val;
         tx_load = 1'b1;
         @(posedge clk); #1;
         tx_load = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] m0, m1, m2;
      int rx0, uf0, ab0;
      rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1; tx_load = 1'b0; tx_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_reset("rst0");

      // Single byte: target sends 3C, host sends A5.
      tx_push(8'h3C);
      check_eq("ready_after_load", 32'(tx_ready), 0);
      rx0 = rx_cnt; uf0 = uf_cnt; ab0 = ab_cnt;
      frame_start();
      check_eq("ready_after_start", 32'(tx_ready), 1);
      check_eq("frame_active_in", 32'(frame_active), 1);
      check_eq("miso_oe_in", 32'(miso_oe), 1);
      xfer(8'hA5, 8, 1, 0, 8'h00, m0);
      wait_idle();
      check_eq("single_miso", 32'(m0), 'h3C);
      check_eq("single_rx_data", 32'(last_rx), 'hA5);
      check_eq("single_rx_pulses", rx_cnt - rx0, 1);
      check_eq("single_underruns", uf_cnt - uf0, 0);
      check_eq("single_aborts", ab_cnt - ab0, 0);
      check_eq("miso_oe_after", 32'(miso_oe), 0);
      check_eq("frame_active_after", 32'(frame_active), 0);

      // Underrun: only 12 queued for a 3-byte frame.
      tx_push(8'h12);
      rx0 = rx_cnt; uf0 = uf_cnt;
      frame_start();
      xfer(8'h01, 8, 0, 0, 8'h00, m0);
      xfer(8'h02, 8, 0, 0, 8'h00, m1);
      xfer(8'h03, 8, 1, 0, 8'h00, m2);
      wait_idle();
      check_eq("uf_miso0", 32'(m0), 'h12);
      check_eq("uf_miso1", 32'(m1), 'hFF);
      check_eq("uf_miso2", 32'(m2), 'hFF);
      check_eq("uf_pulses", uf_cnt - uf0, 2);
      check_eq("uf_rx_pulses", rx_cnt - rx0, 3);
      check_eq("uf_rx_last", 32'(last_rx), 'h03);

      // Late load: 77 arrives on the boundary-load clk, so it goes out one byte later.
      tx_push(8'h5A);
      rx0 = rx_cnt; uf0 = uf_cnt;
      frame_start();
      xfer(8'hC3, 8, 0, 1, 8'h77, m0);
      check_eq("late_pending", 32'(tx_ready), 0);
      xfer(8'h3C, 8, 0, 0, 8'h00, m1);
      xfer(8'h81, 8, 1, 0, 8'h00, m2);
      wait_idle();
      check_eq("late_miso0", 32'(m0), 'h5A);
      check_eq("late_miso1", 32'(m1), 'hFF);
      check_eq("late_miso2", 32'(m2), 'h77);
      check_eq("late_underruns", uf_cnt - uf0, 1);
      check_eq("late_ready_end", 32'(tx_ready), 1);
      check_eq("late_rx_last", 32'(last_rx), 'h81);

      // Abort after 5 bits, then a clean frame.
      rx0 = rx_cnt; ab0 = ab_cnt;
      frame_start();
      xfer(8'hF0, 5, 1, 0, 8'h00, m0);
      wait_idle();
      check_eq("abort_pulses", ab_cnt - ab0, 1);
      check_eq("abort_no_rx", rx_cnt - rx0, 0);
      frame_start();
      xfer(8'h96, 8, 1, 0, 8'h00, m0);
      wait_idle();
      check_eq("post_abort_rx_pulses", rx_cnt - rx0, 1);
      check_eq("post_abort_rx_data", 32'(last_rx), 'h96);
      check_eq("post_abort_miso", 32'(m0), 'hFF);
      check_eq("post_abort_no_abort", ab_cnt - ab0, 1);

      // CRC over "123456789".
      rx0 = rx_cnt;
      frame_start();
      for (int k = 0; k < 9; k++) begin
         xfer(8'h31 + 8'(k), 8, k == 8, 0, 8'h00, m0);
      end
      wait_idle();
      check_eq("crc_rx_pulses", rx_cnt - rx0, 9);
      check_eq("crc_rx_last", 32'(last_rx), 'h39);
`ifdef SPI_TARGET_CRC_EN
      check_eq("crc_value", 32'(crc_out), 'h29B1);
`else
      check_eq("crc_value", 32'(crc_out), 'hFFFF);
`endif

      // Reset mid-frame, release with _ss still low.
      tx_push(8'hAA);
      frame_start();
      xfer(8'hE7, 3, 0, 0, 8'h00, m0);
      rst = 1'b1;
      #1;
      check_reset("rst_mid");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rx0 = rx_cnt;
      xfer(8'h55, 8, 0, 0, 8'h00, m0);
      wait_idle();
      check_eq("rst_lo_frame_active", 32'(frame_active), 0);
      check_eq("rst_lo_miso_oe", 32'(miso_oe), 0);
      check_eq("rst_lo_no_rx", rx_cnt - rx0, 0);
      ss_n = 1'b1;
      wait_idle();
      frame_start();
      xfer(8'h42, 8, 1, 0, 8'h00, m0);
      wait_idle();
      check_eq("rst_recover_rx_pulses", rx_cnt - rx0, 1);
      check_eq("rst_recover_rx_data", 32'(last_rx), 'h42);
      check_eq("rst_recover_miso", 32'(m0), 'hFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
